// File: rtl/adder32.sv
// Registered unsigned adder built on a Kogge-Stone parallel-prefix carry network.
// The prefix tree is purely combinational; only the (WIDTH+1)-bit sum is registered.
module adder32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   r
);

  localparam int LEVELS = $clog2(WIDTH);

  logic [WIDTH-1:0] p_bit;
  logic [WIDTH-1:0] g_acc;
  logic [WIDTH-1:0] p_acc;
  logic [WIDTH-1:0] carry;
  logic [WIDTH:0]   r_d;
  logic [WIDTH:0]   r_q;

  // Each level merges every (G,P) group with the group 2^l bits below it.
  // Low positions see zeros shifted in, which acts as the absent carry-in and
  // leaves their already-complete prefix generate unchanged.
  always_comb begin
    p_bit = a ^ b;
    g_acc = a & b;
    p_acc = p_bit;
    for (int l = 0; l < LEVELS; l++) begin
      g_acc = g_acc | (p_acc & (g_acc << (1 << l)));
      p_acc = p_acc & (p_acc << (1 << l));
    end
    carry = {g_acc[WIDTH-2:0], 1'b0};
    r_d   = {g_acc[WIDTH-1], p_bit ^ carry};
  end

  // Result register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  assign r = r_q;

endmodule

// File: tb/tb_adder32.sv
// Scoreboard bench for adder32: the driver queues the expected sum for every
// driven edge, and a monitor pops and compares one entry after every rising edge.
module tb_adder32;

  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH:0] exp;
    int             tag;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   r;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  adder32 #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .r   (r)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  function automatic logic [WIDTH:0] model_sum(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s;
  endfunction

  // Inputs change on the falling edge; the following rising edge samples them.
  task automatic drive(input logic r_in, input logic [WIDTH-1:0] av,
                       input logic [WIDTH-1:0] bv, input logic [WIDTH:0] ex,
                       input int tag);
    exp_t e;
    @(negedge clk);
    rst = r_in;
    a   = av;
    b   = bv;
    e.exp = ex;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (r !== e.exp) begin
        errors++;
        $display("FAIL sum tag=%0d actual=%h required=%h", e.tag, r, e.exp);
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a   = '0;
    b   = '0;
    void'($urandom(0));

    // Reset holds r at zero regardless of operands
    drive(1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 33'h000000000, 1);
    drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 33'h000000000, 1);

    drive(1'b0, 32'h00000000, 32'h00000000, 33'h000000000, 2);
    drive(1'b0, 32'hFFFFFFFF, 32'h00000001, 33'h100000000, 3);
    drive(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 33'h1FFFFFFFE, 4);
    drive(1'b0, 32'h12345678, 32'h87654321, 33'h099999999, 5);

    // Reset priority over a carry-producing sum, then release
    drive(1'b1, 32'h80000000, 32'h80000000, 33'h000000000, 6);
    drive(1'b0, 32'h80000000, 32'h80000000, 33'h100000000, 7);

    drive(1'b0, 32'hAAAAAAAA, 32'h55555555, 33'h0FFFFFFFF, 8);
    drive(1'b0, 32'hAAAAAAAA, 32'h55555556, 33'h100000000, 9);
    drive(1'b0, 32'h00000001, 32'h7FFFFFFF, 33'h080000000, 11);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 500) begin
        // Mid-stream reset discards the pair sampled on this edge
        drive(1'b1, ra, rb, 33'h000000000, 10);
      end else begin
        drive(1'b0, ra, rb, model_sum(ra, rb), 100);
      end
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder32.md
ADDER32 -- requirements
Module: adder32

Interface
REQ-001 Parameter: WIDTH, default 32, operand width; the block SHALL be verified at WIDTH=32 only.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: a  input  WIDTH  unsigned addend A.
REQ-005 Port: b  input  WIDTH  unsigned addend B.
REQ-006 Port: r  output  WIDTH+1  registered unsigned sum; r[WIDTH] is the carry-out.

Function
REQ-007 Arithmetic: the block SHALL compute a + b as an unsigned (WIDTH+1)-bit value with no truncation and no carry-in.
REQ-008 Latency: the block SHALL present at r the sum of the a and b values sampled at rising edge N from edge N onward, i.e. one clock of latency.
REQ-009 Throughput: the block SHALL accept a new operand pair on every clock, with no handshake, stall or valid signal.
REQ-010 Structure: the block SHALL implement the sum as a parallel-prefix carry network: per-bit generate g=a&b and propagate p=a^b, then log2(WIDTH) = 5 prefix levels combining (G,P) pairs, then sum bit i = p[i] ^ carry[i].
REQ-011 Carry-out: r[WIDTH] SHALL equal the group generate over bits WIDTH-1..0.
REQ-012 The block SHALL register only the final result. The prefix network SHALL be purely combinational between the input pins and the r register.
REQ-013 Overflow: the block SHALL NOT wrap or saturate. Sums of 2^WIDTH or more SHALL appear with r[WIDTH]=1.
REQ-014 Inputs with X/Z values are out of scope. No behaviour is required for them.

Reset
REQ-015 When rst=1 at a rising edge, the block SHALL set r to 0 at that edge, regardless of a and b.
REQ-016 Reset SHALL take priority over the sum update on the same edge.
REQ-017 On the first edge with rst=0, r SHALL load the sum of the a and b present at that edge.
REQ-018 Reset asserted mid-stream SHALL discard the pending sum. There is no other internal state to clear.

Verification
REQ-019 Zero: rst released, a=0x00000000, b=0x00000000 -> r=0x000000000 one edge later.
REQ-020 Full carry ripple: a=0xFFFFFFFF, b=0x00000001 -> r=0x100000000.
REQ-021 Max operands: a=0xFFFFFFFF, b=0xFFFFFFFF -> r=0x1FFFFFFFE. Then a=0x12345678, b=0x87654321 on the next edge -> r=0x099999999, showing back-to-back updates.
REQ-022 Reset priority: a=0x80000000, b=0x80000000 with rst=1 -> r=0x000000000. Deassert rst -> r=0x100000000 at the next edge.
REQ-023 Random: 1000 vectors from $urandom with seed 0, one pair per clock (period 4 ns) -> every r equals the golden a+b (33-bit) of the previous edge.
REQ-024 Alternating bits: a=0xAAAAAAAA, b=0x55555555 -> r=0x0FFFFFFFF. Then b=0x55555556 -> r=0x100000000, showing a long propagate chain.
